cell_lut_ctrl: RTL and testbench

Clocked, arbitrated lookup table holding per-VPI cell rewriting and forwarding entries, shared by all UTOPIA receive channels. It replaces the untimed read/write-function table: one registered read port is arbitrated round-robin among NumRx requesters, and a host write port has priority. A hardware clear sweep invalidates every entry after reset and on request. It sits between the host configuration path and the per-port receive/rewrite logic.

---
 rtl/cell_lut_ctrl_pkg.sv | 18 +
 rtl/cell_lut_ctrl_if.sv | 29 ++
 rtl/cell_lut_ctrl_rr_arbiter.sv | 44 ++++
 rtl/cell_lut_ctrl.sv | 113 +++++++++++
 tb/tb_cell_lut_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cell_lut_ctrl_pkg.sv
// Shared definitions for the cell lookup table and the receive path that uses it.
package cell_lut_ctrl_pkg;

   localparam int LUT_ASIZE  = 8;
   localparam int LUT_DWIDTH = 16;

   typedef enum logic [0:0] {
      LUT_CLEAR = 1'b0,
      LUT_IDLE  = 1'b1
   } lut_state_e;

   // Stored word as seen by the receive/rewrite logic at the default width
   typedef struct packed {
      logic                  valid;
      logic [LUT_DWIDTH-1:0] data;
   } lut_entry_t;

endpackage

// File: rtl/cell_lut_ctrl_if.sv
// Host write port, clear control and the arbitrated multi-channel read port.
interface cell_lut_ctrl_if #(
   parameter int Asize  = 8,
   parameter int Dwidth = 16,
   parameter int NumRx  = 4
);
   logic                    clear_req;
   logic                    init_busy;
   logic                    wr_en;
   logic [Asize-1:0]        wr_addr;
   logic [Dwidth-1:0]       wr_data;
   logic                    wr_ready;
   logic [NumRx-1:0]        rd_req;
   logic [NumRx*Asize-1:0]  rd_addr;
   logic [NumRx-1:0]        rd_gnt;
   logic [NumRx-1:0]        rd_valid;
   logic [Dwidth-1:0]       rd_data;
   logic                    rd_hit;

   modport master (
      output clear_req, wr_en, wr_addr, wr_data, rd_req, rd_addr,
      input  init_busy, wr_ready, rd_gnt, rd_valid, rd_data, rd_hit
   );

   modport slave (
      input  clear_req, wr_en, wr_addr, wr_data, rd_req, rd_addr,
      output init_busy, wr_ready, rd_gnt, rd_valid, rd_data, rd_hit
   );
endinterface

// File: rtl/cell_lut_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester above the last
// granted index, wrapping. The pointer moves only when a grant is issued.
module cell_lut_ctrl_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_req,
   input  logic         i_enable,
   output logic [N-1:0] o_gnt
);
   localparam int            PW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW-1:0] LAST_RST = PW'(N - 1);

   logic [PW-1:0] r_last;
   logic [PW-1:0] w_sel;
   logic [PW-1:0] w_next;
   logic          w_any;

   // Scan requesters starting just above the last winner
   always_comb begin
      o_gnt  = '0;
      w_next = r_last;
      w_any  = 1'b0;
      w_sel  = '0;
      for (int k = 1; k <= N; k++) begin
         w_sel = PW'((int'(r_last) + k) % N);
         if (i_enable && !w_any && i_req[w_sel]) begin
            o_gnt[w_sel] = 1'b1;
            w_next       = w_sel;
            w_any        = 1'b1;
         end
      end
   end

   // Remember the last granted channel; reset so channel 0 wins first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last <= LAST_RST;
      end else if (w_any) begin
         r_last <= w_next;
      end
   end
endmodule

// File: rtl/cell_lut_ctrl.sv
// Cell rewriting/forwarding lookup table shared by the receive channels.
// A clear sweep invalidates every entry after reset or on request; a host
// write has priority over the round-robin arbitrated registered read port.
module cell_lut_ctrl
   import cell_lut_ctrl_pkg::*;
#(
   parameter int Asize  = LUT_ASIZE,
   parameter int Dwidth = LUT_DWIDTH,
   parameter int NumRx  = 4
) (
   input  logic          clk,
   input  logic          rst,
   cell_lut_ctrl_if.slave io_bus
);
   localparam int               Arange   = 1 << Asize;
   localparam logic [0:0]       S_CLEAR  = 1'(LUT_CLEAR);
   localparam logic [0:0]       S_IDLE   = 1'(LUT_IDLE);
   localparam logic [Asize-1:0] CNT_LAST = Asize'(Arange - 1);

   typedef struct packed {
      logic              valid;
      logic [Dwidth-1:0] data;
   } entry_t;

   logic [0:0]       r_state;
   logic [Asize-1:0] r_cnt;
   entry_t           r_mem [Arange];
   entry_t           r_rd;
   logic [NumRx-1:0] r_rd_valid;

   logic             w_busy;
   logic             w_rd_en;
   logic             w_mem_we;
   logic [Asize-1:0] w_mem_waddr;
   entry_t           w_mem_wdata;
   logic [Asize-1:0] w_rd_addr;
   logic [NumRx-1:0] w_gnt;

   assign w_busy  = (r_state == S_CLEAR);
   // A host write owns the cycle; reads wait with their requests held
   assign w_rd_en = !w_busy && !io_bus.wr_en;

   // Sweep one entry per cycle, then idle until the next clear request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
      end else if (w_busy) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
         end
      end else if (io_bus.clear_req) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
      end
   end

   // Single write port: the sweep writes invalid zeros, the host writes valid data
   always_comb begin
      w_mem_we          = w_busy || io_bus.wr_en;
      w_mem_waddr       = w_busy ? r_cnt : io_bus.wr_addr;
      w_mem_wdata.valid = !w_busy;
      w_mem_wdata.data  = w_busy ? '0 : io_bus.wr_data;
   end

   // Table storage, no reset: contents are defined by the sweep
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdata;
      end
   end

   cell_lut_ctrl_rr_arbiter #(
      .N (NumRx)
   ) u_rr_arbiter (
      .clk      (clk),
      .rst      (rst),
      .i_req    (io_bus.rd_req),
      .i_enable (w_rd_en),
      .o_gnt    (w_gnt)
   );

   // Select the address of the granted channel
   always_comb begin
      w_rd_addr = '0;
      for (int i = 0; i < NumRx; i++) begin
         if (w_gnt[i]) begin
            w_rd_addr = io_bus.rd_addr[i*Asize +: Asize];
         end
      end
   end

   // Registered read: data returns the cycle after the grant and holds until the next
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd       <= '0;
         r_rd_valid <= '0;
      end else begin
         r_rd_valid <= w_gnt;
         if (|w_gnt) begin
            r_rd <= r_mem[w_rd_addr];
         end
      end
   end

   assign io_bus.init_busy = w_busy;
   assign io_bus.wr_ready  = !w_busy;
   assign io_bus.rd_gnt    = w_gnt;
   assign io_bus.rd_valid  = r_rd_valid;
   assign io_bus.rd_data   = r_rd.data;
   assign io_bus.rd_hit    = r_rd.valid;
endmodule

// File: tb/tb_cell_lut_ctrl.sv
// Bench for cell_lut_ctrl at Asize=4, Dwidth=16, NumRx=4.
module tb_cell_lut_ctrl;
   localparam int AS = 4;
   localparam int DW = 16;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   chk_en   = 1'b0;

   cell_lut_ctrl_if #(.Asize(AS), .Dwidth(DW), .NumRx(NR)) bus ();

   cell_lut_ctrl #(.Asize(AS), .Dwidth(DW), .NumRx(NR)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          busy_left;
   int          last;
   logic [16:0] mmem [16];
   logic [3:0]  exp_valid;
   logic [15:0] exp_data;
   logic        exp_hit;
   logic [3:0]  m_g;
   logic [3:0]  m_a;

   function automatic logic [3:0] calc_gnt();
      logic [3:0] g;
      g = 4'b0;
      if (rst || busy_left > 0 || bus.wr_en) return g;
      for (int k = 1; k <= 4; k++) begin
         if (bus.rd_req[(last + k) % 4]) begin
            g[(last + k) % 4] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_left = 16;
         last      = 3;
         exp_valid = 4'b0;
         exp_data  = 16'h0;
         exp_hit   = 1'b0;
         for (int i = 0; i < 16; i++) mmem[i] = 17'h0;
      end else begin
         m_g       = calc_gnt();
         exp_valid = m_g;
         for (int i = 0; i < 4; i++) begin
            if (m_g[i]) begin
               m_a = bus.rd_addr[i*4 +: 4];
               {exp_hit, exp_data} = mmem[m_a];
               last = i;
            end
         end
         if (busy_left > 0) begin
            busy_left--;
         end else begin
            if (bus.wr_en) mmem[bus.wr_addr] = {1'b1, bus.wr_data};
            if (bus.clear_req) begin
               for (int i = 0; i < 16; i++) mmem[i] = 17'h0;
               busy_left = 16;
            end
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_init_busy", 32'(bus.init_busy), 32'(busy_left > 0));
         check("m_wr_ready",  32'(bus.wr_ready),  32'(busy_left == 0));
         check("m_rd_gnt",    32'(bus.rd_gnt),    32'(calc_gnt()));
         check("m_rd_valid",  32'(bus.rd_valid),  32'(exp_valid));
         check("m_rd_data",   32'(bus.rd_data),   32'(exp_data));
         check("m_rd_hit",    32'(bus.rd_hit),    32'(exp_hit));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input int ch, input logic [3:0] a,
                          output logic [15:0] d, output logic h, output int lat);
      bit got;
      got = 1'b0;
      lat = 0;
      bus.rd_addr[ch*4 +: 4] = a;
      bus.rd_req[ch] = 1'b1;
      while (!got && lat < 40) begin
         @(negedge clk);
         if (bus.rd_gnt[ch]) got = 1'b1;
         step();
         lat++;
      end
      bus.rd_req[ch] = 1'b0;
      if (!got) check("rd_gnt_timeout", 32'(0), 32'(1));
      @(negedge clk);
      check("rd_valid_after_gnt", 32'(bus.rd_valid[ch]), 32'(1));
      d = bus.rd_data;
      h = bus.rd_hit;
      step();
   endtask

   task automatic count_busy(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.init_busy) break;
         n++;
      end
      step();
   endtask

   logic [15:0] d;
   logic        h;
   int          lat;
   int          n;
   logic [15:0] wdat [3] = '{16'h1234, 16'h5678, 16'h9ABC};

   initial begin
      bus.clear_req = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.rd_req    = '0;
      bus.rd_addr   = '0;
      #1;
      rst    = 1'b1;
      chk_en = 1'b1;

      // Reset values
      @(negedge clk);
      check("rst_init_busy", 32'(bus.init_busy), 32'(1));
      check("rst_wr_ready",  32'(bus.wr_ready),  32'(0));
      check("rst_rd_valid",  32'(bus.rd_valid),  32'(0));
      check("rst_rd_data",   32'(bus.rd_data),   32'(0));
      step();
      rst = 1'b0;
      count_busy(n);
      check("sweep_len_reset", 32'(n), 32'(16));
      do_read(0, 4'd5, d, h, lat);
      check("rd5_lat",  32'(lat), 32'(1));
      check("rd5_data", 32'(d),   32'(16'h0000));
      check("rd5_hit",  32'(h),   32'(0));

      // Write then read back on channel 2
      bus.wr_en   = 1'b1;
      bus.wr_addr = 4'd3;
      bus.wr_data = 16'hBEEF;
      @(negedge clk);
      check("wr_ready_idle", 32'(bus.wr_ready), 32'(1));
      step();
      bus.wr_en = 1'b0;
      do_read(2, 4'd3, d, h, lat);
      check("rd3_lat",  32'(lat), 32'(1));
      check("rd3_data", 32'(d),   32'(16'hBEEF));
      check("rd3_hit",  32'(h),   32'(1));

      // All channels requesting: last winner was 2, so order is 3,0,1,2,...
      bus.rd_addr = 16'h3333;
      bus.rd_req  = 4'hF;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("rr_gnt", 32'(bus.rd_gnt), 32'(4'b0001 << ((3 + k) % 4)));
         if (k > 0) begin
            check("rr_valid", 32'(bus.rd_valid), 32'(4'b0001 << ((2 + k) % 4)));
            check("rr_data",  32'(bus.rd_data),  32'(16'hBEEF));
         end
         step();
      end
      bus.rd_req = 4'h0;

      // Writes block the pending channel-1 read
      bus.rd_addr[1*4 +: 4] = 4'd7;
      bus.rd_req[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = 4'(7 + i);
         bus.wr_data = wdat[i];
         @(negedge clk);
         check("wr_blocks_gnt", 32'(bus.rd_gnt), 32'(0));
         step();
      end
      bus.wr_en = 1'b0;
      @(negedge clk);
      check("gnt_after_wr", 32'(bus.rd_gnt), 32'(4'b0010));
      step();
      bus.rd_req[1] = 1'b0;
      @(negedge clk);
      check("valid_after_wr", 32'(bus.rd_valid), 32'(4'b0010));
      check("data_after_wr",  32'(bus.rd_data),  32'(16'h1234));
      check("hit_after_wr",   32'(bus.rd_hit),   32'(1));
      step();

      // Clear with a read granted in the same cycle; second request mid-sweep ignored
      bus.clear_req = 1'b1;
      bus.rd_addr[0 +: 4] = 4'd3;
      bus.rd_req[0] = 1'b1;
      @(negedge clk);
      check("clr_cycle_gnt", 32'(bus.rd_gnt), 32'(4'b0001));
      step();
      bus.clear_req = 1'b0;
      bus.rd_req[0] = 1'b0;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("preclr_valid", 32'(bus.rd_valid), 32'(4'b0001));
            check("preclr_data",  32'(bus.rd_data),  32'(16'hBEEF));
            check("preclr_hit",   32'(bus.rd_hit),   32'(1));
         end
         if (!bus.init_busy) break;
         n++;
         step();
         bus.clear_req = (n == 5);
      end
      bus.clear_req = 1'b0;
      check("sweep_len_clear", 32'(n), 32'(16));
      step();
      do_read(0, 4'd3, d, h, lat);
      check("clr_rd3_hit",  32'(h), 32'(0));
      check("clr_rd3_data", 32'(d), 32'(0));
      do_read(1, 4'd7, d, h, lat);
      check("clr_rd7_hit",  32'(h), 32'(0));

      // Reset the cycle after a grant: the read is lost, sweep restarts
      bus.rd_addr[0 +: 4] = 4'd3;
      bus.rd_req[0] = 1'b1;
      @(negedge clk);
      check("pre_rst_gnt", 32'(bus.rd_gnt), 32'(4'b0001));
      step();
      bus.rd_req[0] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst_kills_valid", 32'(bus.rd_valid), 32'(0));
      check("rst_busy",        32'(bus.init_busy), 32'(1));
      step();
      rst = 1'b0;
      count_busy(n);
      check("sweep_len_rerst", 32'(n), 32'(16));
      do_read(3, 4'd9, d, h, lat);
      check("rerst_lat", 32'(lat), 32'(1));
      check("rerst_hit", 32'(h),   32'(0));

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
